// File: rtl/clip_player.sv
// Multi-clip sample player: walks one clip of a shared sample ROM and feeds Audio_Controller.
// Latency: rom_addr one cycle after play_req, sample captured ROM_LAT cycles after each address, strobe one cycle later.
// Backpressure: one-deep pending slot held while audio_out_allowed is low; newer samples overwrite it and bump overrun_cnt.
module clip_player #(
    parameter int                            ADDR_W      = 18,
    parameter int                            SAMPLE_W    = 6,
    parameter int                            OUT_W       = 32,
    parameter int                            NUM_CLIPS   = 4,
    parameter int                            SEL_W       = 2,
    parameter logic [NUM_CLIPS*ADDR_W-1:0]   CLIP_STARTS = {18'd83255, 18'd66983, 18'd16396, 18'd0},
    parameter logic [NUM_CLIPS*ADDR_W-1:0]   CLIP_ENDS   = {18'd137138, 18'd83254, 18'd66982, 18'd16395},
    parameter int                            DIV         = 1200,
    parameter int                            ROM_LAT     = 1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                play_req,
    input  logic [SEL_W-1:0]    clip_sel,
    input  logic                loop_mode,
    input  logic                stop_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic [OUT_W-1:0]    sample_out,
    output logic                write_audio_out,
    output logic                busy,
    output logic                done,
    output logic                sel_err,
    output logic [7:0]          overrun_cnt
);

    localparam int                 CNT_W       = $clog2(DIV);
    localparam logic [CNT_W-1:0]   DIV_LAST    = CNT_W'(DIV - 1);
    localparam logic [SEL_W:0]     NUM_CLIPS_V = (SEL_W + 1)'(NUM_CLIPS);
    localparam int                 PAD_W       = OUT_W - SAMPLE_W;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   end_addr;
    logic                loop_r;
    logic [CNT_W-1:0]    div_cnt;
    logic                pending;
    logic [ROM_LAT-1:0]  upd_pipe;

    logic                sel_ok;
    logic [SEL_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   sel_start;
    logic [ADDR_W-1:0]   sel_end;
    logic                tick;
    logic                cap_vld;
    logic                issue;

    assign sel_ok    = ({1'b0, clip_sel} < NUM_CLIPS_V);
    assign sel_idx   = sel_ok ? clip_sel : '0;
    assign sel_start = CLIP_STARTS[sel_idx*ADDR_W +: ADDR_W];
    assign sel_end   = CLIP_ENDS[sel_idx*ADDR_W +: ADDR_W];
    assign tick      = (div_cnt == DIV_LAST);
    assign cap_vld   = upd_pipe[ROM_LAT-1];
    assign issue     = pending && audio_out_allowed;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            rom_addr        <= '0;
            start_addr      <= '0;
            end_addr        <= '0;
            loop_r          <= 1'b0;
            div_cnt         <= '0;
            pending         <= 1'b0;
            upd_pipe        <= '0;
            sample_out      <= '0;
            write_audio_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sel_err         <= 1'b0;
            overrun_cnt     <= '0;
        end else begin
            done            <= 1'b0;
            sel_err         <= play_req && !stop_req && !sel_ok;
            write_audio_out <= 1'b0;
            if (stop_req && state == PLAY) begin
                state      <= IDLE;
                busy       <= 1'b0;
                sample_out <= '0;
                pending    <= 1'b0;
                upd_pipe   <= '0;
                div_cnt    <= '0;
            end else if (play_req && !stop_req && sel_ok) begin
                state      <= PLAY;
                busy       <= 1'b1;
                rom_addr   <= sel_start;
                start_addr <= sel_start;
                end_addr   <= sel_end;
                loop_r     <= loop_mode;
                div_cnt    <= '0;
                pending    <= 1'b0;
                upd_pipe   <= ROM_LAT'(1);
            end else if (state == PLAY) begin
                if (tick && rom_addr == end_addr && !loop_r) begin
                    // The end sample has had its full period; finish without wrapping.
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    sample_out <= '0;
                    pending    <= 1'b0;
                    upd_pipe   <= '0;
                    div_cnt    <= '0;
                end else begin
                    div_cnt  <= tick ? '0 : div_cnt + 1'b1;
                    upd_pipe <= (upd_pipe << 1) | ROM_LAT'(tick);
                    if (tick)
                        rom_addr <= (rom_addr == end_addr) ? start_addr : rom_addr + 1'b1;
                    if (cap_vld) begin
                        sample_out <= {rom_q, {PAD_W{1'b0}}};
                        if (pending && overrun_cnt != 8'hFF)
                            overrun_cnt <= overrun_cnt + 8'd1;
                    end
                    // A strobe issued on a capture edge carries the fresh sample, so nothing stays pending.
                    write_audio_out <= issue;
                    if (issue)
                        pending <= 1'b0;
                    else if (cap_vld)
                        pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clip_player.sv
// Bench for clip_player: directed scenarios with literal expectations plus random play/stop/backpressure traffic.
// An event-level model (clip index, period phase, queue of pending ROM captures) is compared every cycle.
module tb_clip_player;

    localparam int AW   = 18;
    localparam int SW   = 6;
    localparam int OW   = 32;
    localparam int NCL  = 3;
    localparam int DIVP = 4;
    localparam int LAT  = 1;
    localparam logic [NCL*AW-1:0] STARTS = {18'd262139, 18'd6, 18'd0};
    localparam logic [NCL*AW-1:0] ENDS   = {18'd262143, 18'd6, 18'd5};

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic          play_req = 1'b0;
    logic [1:0]    clip_sel = 2'd0;
    logic          loop_mode = 1'b0;
    logic          stop_req = 1'b0;
    logic          audio_out_allowed = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [SW-1:0] rom_q;
    logic [OW-1:0] sample_out;
    logic          write_audio_out, busy, done, sel_err;
    logic [7:0]    overrun_cnt;

    int checks = 0;
    int failures = 0;
    int n_wr = 0;
    int n_done = 0;
    bit cmp_en = 0;

    clip_player #(
        .ADDR_W(AW), .SAMPLE_W(SW), .OUT_W(OW), .NUM_CLIPS(NCL), .SEL_W(2),
        .CLIP_STARTS(STARTS), .CLIP_ENDS(ENDS), .DIV(DIVP), .ROM_LAT(LAT)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .play_req(play_req), .clip_sel(clip_sel),
        .loop_mode(loop_mode), .stop_req(stop_req), .rom_addr(rom_addr), .rom_q(rom_q),
        .audio_out_allowed(audio_out_allowed), .sample_out(sample_out),
        .write_audio_out(write_audio_out), .busy(busy), .done(done), .sel_err(sel_err),
        .overrun_cnt(overrun_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [SW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[5:0] ^ a[11:6] ^ 6'h2A;
    endfunction

    assign rom_q = rom_fn(rom_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [AW-1:0] a; } cap_t;
    cap_t          capq[$];
    int            cyc = 0;
    bit            m_play, m_loop, m_pend, m_wr, m_done, m_sel, mi_issue, mi_cap;
    logic [AW-1:0] m_start, m_end, m_addr, mi_ca;
    logic [OW-1:0] m_samp;
    int            m_ph, m_ovr;

    task automatic m_leave();
        m_play = 0; m_samp = '0; m_pend = 0; m_wr = 0; m_ph = 0;
        capq.delete();
    endtask

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            m_play = 0; m_loop = 0; m_pend = 0; m_wr = 0; m_done = 0; m_sel = 0;
            m_start = '0; m_end = '0; m_addr = '0; m_samp = '0; m_ph = 0; m_ovr = 0;
            capq.delete();
        end else begin
            cyc++;
            m_done = 0; m_sel = 0;
            mi_issue = m_pend && audio_out_allowed;
            if (stop_req && m_play) begin
                m_leave();
            end else if (play_req && !stop_req && clip_sel < NCL) begin
                m_play = 1; m_loop = loop_mode;
                m_start = STARTS[clip_sel*AW +: AW];
                m_end = ENDS[clip_sel*AW +: AW];
                m_addr = m_start; m_ph = 0; m_pend = 0; m_wr = 0;
                capq.delete();
                capq.push_back('{cyc + LAT, m_start});
            end else begin
                if (play_req && !stop_req) m_sel = 1;
                if (m_play) begin
                    if (m_ph == DIVP - 1 && m_addr == m_end && !m_loop) begin
                        m_leave();
                        m_done = 1;
                    end else begin
                        mi_cap = 0;
                        if (capq.size() > 0 && capq[0].due == cyc) begin
                            mi_cap = 1; mi_ca = capq[0].a; void'(capq.pop_front());
                        end
                        if (mi_cap) begin
                            m_samp = {rom_fn(mi_ca), 26'd0};
                            if (m_pend && m_ovr < 255) m_ovr++;
                        end
                        m_wr = mi_issue;
                        if (mi_issue) m_pend = 0;
                        else if (mi_cap) m_pend = 1;
                        if (m_ph == DIVP - 1) begin
                            m_ph = 0;
                            m_addr = (m_addr == m_end) ? m_start : m_addr + 1'b1;
                            capq.push_back('{cyc + LAT, m_addr});
                        end else begin
                            m_ph++;
                        end
                    end
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (write_audio_out) n_wr++;
        if (done) n_done++;
        if (cmp_en) begin
            chk("rom_addr", rom_addr, m_addr);
            chk("sample_out", sample_out, m_samp);
            chk("write_audio_out", write_audio_out, m_wr);
            chk("busy", busy, m_play);
            chk("done", done, m_done);
            chk("sel_err", sel_err, m_sel);
            chk("overrun_cnt", overrun_cnt, m_ovr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic play(input logic [1:0] sel, input logic lp);
        play_req = 1; clip_sel = sel; loop_mode = lp;
        step(1);
        play_req = 0;
    endtask

    initial begin
        #23;
        chk("rst_addr", rom_addr, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", write_audio_out, 0);
        resetn = 1;
        cmp_en = 1;
        step(1);

        // backpressure: 10 samples with no room, then release
        audio_out_allowed = 0;
        play(2'd0, 1'b1);
        chk("bp_busy", busy, 1);
        step(37);
        chk("bp_overrun", overrun_cnt, 9);
        chk("bp_no_wr", write_audio_out, 0);
        audio_out_allowed = 1;
        n_wr = 0;
        step(1);
        chk("bp_release_wr", write_audio_out, 1);
        chk("bp_latest_sample", sample_out, 32'hA400_0000);
        step(1);
        chk("bp_single_wr", n_wr, 1);

        // stop and play together mid-clip: stop wins
        stop_req = 1; play_req = 1; clip_sel = 2'd1;
        n_wr = 0; n_done = 0;
        step(1);
        stop_req = 0; play_req = 0;
        chk("stop_busy", busy, 0);
        chk("stop_sample", sample_out, 0);
        step(10);
        chk("stop_no_wr", n_wr, 0);
        chk("stop_no_done", n_done, 0);

        // one-shot clip at the top of the address space
        n_wr = 0; n_done = 0;
        play(2'd2, 1'b0);
        chk("os_first_addr", rom_addr, 262139);
        step(1);
        chk("os_first_sample", sample_out, 32'hB800_0000);
        chk("os_no_wr_yet", write_audio_out, 0);
        step(1);
        chk("os_first_wr", write_audio_out, 1);
        step(2);
        chk("os_second_addr", rom_addr, 262140);
        step(15);
        chk("os_end_addr", rom_addr, 262143);
        chk("os_busy_before_done", busy, 1);
        step(1);
        chk("os_done", done, 1);
        chk("os_busy_fall", busy, 0);
        chk("os_sample_zero", sample_out, 0);
        chk("os_no_wrap", rom_addr, 262143);
        step(1);
        chk("os_done_once", n_done, 1);
        chk("os_strobes", n_wr, 5);

        // looped clip wraps to its start with no gap
        n_done = 0;
        play(2'd0, 1'b1);
        step(20);
        chk("loop_end_addr", rom_addr, 5);
        step(4);
        chk("loop_wrap_addr", rom_addr, 0);
        chk("loop_busy", busy, 1);

        // preempt a looping clip
        play(2'd2, 1'b1);
        chk("pre_addr2", rom_addr, 262139);
        step(6);
        play(2'd0, 1'b0);
        chk("pre_addr0", rom_addr, 0);
        step(3);
        chk("pre_div_restart", rom_addr, 0);
        step(1);
        chk("pre_next_addr", rom_addr, 1);
        chk("pre_no_done", n_done, 0);
        step(30);

        // invalid clip select, idle then while playing a start==end clip
        clip_sel = 2'd3; play_req = 1;
        step(1);
        play_req = 0;
        chk("selerr_idle", sel_err, 1);
        chk("selerr_idle_busy", busy, 0);
        play(2'd1, 1'b1);
        step(2);
        clip_sel = 2'd3; play_req = 1;
        step(1);
        play_req = 0;
        chk("selerr_play", sel_err, 1);
        chk("selerr_play_busy", busy, 1);
        chk("selerr_play_addr", rom_addr, 6);
        step(1);
        chk("selerr_pulse", sel_err, 0);

        // asynchronous reset in the middle of playback
        #3 resetn = 0;
        #1;
        chk("arst_addr", rom_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun_cnt, 0);
        chk("arst_sample", sample_out, 0);
        #2 resetn = 1;
        step(1);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            play_req = (r < 4);
            stop_req = (r >= 4 && r < 6);
            if (play_req) begin
                clip_sel = 2'($urandom_range(0, 3));
                loop_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) audio_out_allowed = ~audio_out_allowed;
            step(1);
        end
        play_req = 0; stop_req = 0;
        step(2);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
